// File: rtl/biquad_coef_loader.sv
// Biquad coefficient loader: collects 5-word coefficient frames into a shadow
// register and copies them into one section of the active bank on a
// sample-boundary strobe, so a section never runs on mixed old/new coefficients.
module biquad_coef_loader #(
  parameter int                 SECTIONS = 4,
  parameter int                 SEC_W    = 2,
  parameter logic signed [15:0] UNITY    = 16'sh4000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [15:0]              wr_data,
  input  logic [SEC_W-1:0]         wr_sec,
  input  logic                     abort,
  input  logic                     commit_en,
  output logic [SECTIONS*16-1:0]   coef_b0,
  output logic [SECTIONS*16-1:0]   coef_b1,
  output logic [SECTIONS*16-1:0]   coef_b2,
  output logic [SECTIONS*16-1:0]   coef_a1,
  output logic [SECTIONS*16-1:0]   coef_a2,
  output logic                     busy,
  output logic                     updated,
  output logic                     err
);

  typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;

  state_t           state;
  logic [2:0]       count;
  logic [SEC_W-1:0] sec_q;
  logic [15:0]      shadow [5];

  logic [15:0] b0_q [SECTIONS];
  logic [15:0] b1_q [SECTIONS];
  logic [15:0] b2_q [SECTIONS];
  logic [15:0] a1_q [SECTIONS];
  logic [15:0] a2_q [SECTIONS];

  logic xfer;
  logic sec_bad;

  assign xfer    = wr_valid & wr_ready;
  assign sec_bad = (32'(sec_q) >= 32'(SECTIONS));

  // Pack the active bank onto the per-coefficient output buses.
  for (genvar k = 0; k < SECTIONS; k++) begin : g_pack
    assign coef_b0[16*k +: 16] = b0_q[k];
    assign coef_b1[16*k +: 16] = b1_q[k];
    assign coef_b2[16*k +: 16] = b2_q[k];
    assign coef_a1[16*k +: 16] = a1_q[k];
    assign coef_a2[16*k +: 16] = a2_q[k];
  end

  // Frame FSM, shadow capture and active-bank commit, all with registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order in this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ready <= 1'b1;
      busy     <= 1'b0;
      updated  <= 1'b0;
      err      <= 1'b0;
      count    <= '0;
      sec_q    <= '0;
      for (int i = 0; i < 5; i++) shadow[i] <= '0;
      // NOTE: the active bank is deliberately reset (unlike a plain RAM) so the
      // biquads come out of reset as pass-through filters.
      for (int k = 0; k < SECTIONS; k++) begin
        b0_q[k] <= UNITY;
        b1_q[k] <= '0;
        b2_q[k] <= '0;
        a1_q[k] <= '0;
        a2_q[k] <= '0;
      end
    end else begin
      updated <= 1'b0;
      err     <= 1'b0;
      if (abort) begin
        // Abort beats any word or commit presented in the same cycle.
        state    <= IDLE;
        wr_ready <= 1'b1;
        busy     <= 1'b0;
        count    <= '0;
        sec_q    <= '0;
        for (int i = 0; i < 5; i++) shadow[i] <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (xfer) begin
              shadow[0] <= wr_data;
              sec_q     <= wr_sec;
              count     <= 3'd1;
              state     <= LOAD;
              busy      <= 1'b1;
            end
          end
          LOAD: begin
            if (xfer) begin
              shadow[count] <= wr_data;
              count         <= count + 3'd1;
              if (count == 3'd4) begin
                if (sec_bad) begin
                  // Out-of-range section: drop the whole frame.
                  err   <= 1'b1;
                  state <= IDLE;
                  busy  <= 1'b0;
                  count <= '0;
                end else begin
                  state    <= PEND;
                  wr_ready <= 1'b0;
                end
              end
            end
          end
          PEND: begin
            if (commit_en) begin
              for (int k = 0; k < SECTIONS; k++) begin
                if (32'(sec_q) == 32'(k)) begin
                  b0_q[k] <= shadow[0];
                  b1_q[k] <= shadow[1];
                  b2_q[k] <= shadow[2];
                  a1_q[k] <= shadow[3];
                  a2_q[k] <= shadow[4];
                end
              end
              updated  <= 1'b1;
              state    <= IDLE;
              wr_ready <= 1'b1;
              busy     <= 1'b0;
              count    <= '0;
            end
          end
          default: begin
            state    <= IDLE;
            wr_ready <= 1'b1;
            busy     <= 1'b0;
            count    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_biquad_coef_loader.sv
// Directed bench for biquad_coef_loader: a 4-section instance for the main
// scenarios and a 3-section instance for the out-of-range section error.
module tb_biquad_coef_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // 4-section DUT
  logic        wr_valid = 1'b0, abort = 1'b0, commit_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_sec = '0;
  logic        wr_ready, busy, updated, err;
  logic [63:0] coef_b0, coef_b1, coef_b2, coef_a1, coef_a2;

  // 3-section DUT
  logic        wr_valid3 = 1'b0, abort3 = 1'b0, commit_en3 = 1'b0;
  logic [15:0] wr_data3 = '0;
  logic [1:0]  wr_sec3 = '0;
  logic        wr_ready3, busy3, updated3, err3;
  logic [47:0] coef3_b0, coef3_b1, coef3_b2, coef3_a1, coef3_a2;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected active bank of the 4-section DUT
  logic [15:0] e_b0 [4];
  logic [15:0] e_b1 [4];
  logic [15:0] e_b2 [4];
  logic [15:0] e_a1 [4];
  logic [15:0] e_a2 [4];

  always #5 clk = ~clk;

  biquad_coef_loader #(.SECTIONS(4), .SEC_W(2), .UNITY(16'sh4000)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_sec(wr_sec), .abort(abort), .commit_en(commit_en),
    .coef_b0(coef_b0), .coef_b1(coef_b1), .coef_b2(coef_b2),
    .coef_a1(coef_a1), .coef_a2(coef_a2),
    .busy(busy), .updated(updated), .err(err)
  );

  biquad_coef_loader #(.SECTIONS(3), .SEC_W(2), .UNITY(16'sh4000)) dut3 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid3), .wr_ready(wr_ready3),
    .wr_data(wr_data3), .wr_sec(wr_sec3), .abort(abort3), .commit_en(commit_en3),
    .coef_b0(coef3_b0), .coef_b1(coef3_b1), .coef_b2(coef3_b2),
    .coef_a1(coef3_a1), .coef_a2(coef3_a2),
    .busy(busy3), .updated(updated3), .err(err3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      e_b0[k] = 16'h4000; e_b1[k] = '0; e_b2[k] = '0; e_a1[k] = '0; e_a2[k] = '0;
    end
  endtask

  task automatic model_commit(input int s, input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3, input logic [15:0] w4);
    e_b0[s] = w0; e_b1[s] = w1; e_b2[s] = w2; e_a1[s] = w3; e_a2[s] = w4;
  endtask

  task automatic check_bank(input string tag);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s b0[%0d]", tag, k), 64'(coef_b0[16*k +: 16]), 64'(e_b0[k]));
      check($sformatf("%s b1[%0d]", tag, k), 64'(coef_b1[16*k +: 16]), 64'(e_b1[k]));
      check($sformatf("%s b2[%0d]", tag, k), 64'(coef_b2[16*k +: 16]), 64'(e_b2[k]));
      check($sformatf("%s a1[%0d]", tag, k), 64'(coef_a1[16*k +: 16]), 64'(e_a1[k]));
      check($sformatf("%s a2[%0d]", tag, k), 64'(coef_a2[16*k +: 16]), 64'(e_a2[k]));
    end
  endtask

  // Present one word on the 4-section DUT for a single cycle.
  task automatic put_word(input logic [15:0] d, input logic [1:0] s, input logic cm);
    wr_valid  = 1'b1;
    wr_data   = d;
    wr_sec    = s;
    commit_en = cm;
    tick();
    wr_valid  = 1'b0;
    commit_en = 1'b0;
  endtask

  task automatic send_frame(input logic [1:0] s, input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3, input logic [15:0] w4,
                            input logic commit_last);
    put_word(w0, s, 1'b0);
    put_word(w1, 2'd0, 1'b0);
    put_word(w2, 2'd0, 1'b0);
    put_word(w3, 2'd0, 1'b0);
    put_word(w4, 2'd0, commit_last);
  endtask

  task automatic pulse_commit();
    commit_en = 1'b1;
    tick();
    commit_en = 1'b0;
  endtask

  initial begin
    model_reset();

    // 1. Reset and idle
    tick(); tick();
    rst = 1'b0;
    tick();
    check_bank("reset");
    check("reset wr_ready", 64'(wr_ready), 64'd1);
    check("reset busy", 64'(busy), 64'd0);
    check("reset updated", 64'(updated), 64'd0);
    check("reset err", 64'(err), 64'd0);

    // 2. Frame to section 2, commit three cycles after word 4
    send_frame(2'd2, 16'd1000, -16'sd2000, 16'd1000, -16'sd3000, 16'd1500, 1'b0);
    check("t2 pend wr_ready", 64'(wr_ready), 64'd0);
    check("t2 pend busy", 64'(busy), 64'd1);
    tick(); tick();
    check_bank("t2 pend unchanged");
    pulse_commit();
    model_commit(2, 16'd1000, -16'sd2000, 16'd1000, -16'sd3000, 16'd1500);
    check_bank("t2 commit");
    check("t2 updated", 64'(updated), 64'd1);
    check("t2 busy after", 64'(busy), 64'd0);
    check("t2 wr_ready after", 64'(wr_ready), 64'd1);

    // 3. Back-to-back frame to section 0; commit with word 4 is ignored
    send_frame(2'd0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 1'b1);
    check("t3 updated pulse ends", 64'(updated), 64'd0);
    check("t3 no commit with w4", 64'(updated), 64'd0);
    check_bank("t3 ignored commit");
    tick();
    check("t3 wr_ready held", 64'(wr_ready), 64'd0);
    check("t3 busy held", 64'(busy), 64'd1);
    pulse_commit();
    model_commit(0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555);
    check("t3 updated", 64'(updated), 64'd1);
    check_bank("t3 commit");
    tick();
    check("t3 updated single", 64'(updated), 64'd0);

    // 4. Abort after word 2, with a word presented alongside the abort
    put_word(16'hAAAA, 2'd1, 1'b0);
    put_word(16'hBBBB, 2'd0, 1'b0);
    tick();                              // valid gap mid-frame
    check("t4 gap busy", 64'(busy), 64'd1);
    check("t4 gap wr_ready", 64'(wr_ready), 64'd1);
    put_word(16'hCCCC, 2'd0, 1'b0);
    abort = 1'b1;
    put_word(16'hDDDD, 2'd0, 1'b0);
    abort = 1'b0;
    check("t4 abort busy", 64'(busy), 64'd0);
    check("t4 abort wr_ready", 64'(wr_ready), 64'd1);
    pulse_commit();                      // commit in IDLE has no effect
    check("t4 idle commit", 64'(updated), 64'd0);
    check_bank("t4 after abort");
    send_frame(2'd1, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 1'b0);
    pulse_commit();
    model_commit(1, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505);
    check("t4 updated", 64'(updated), 64'd1);
    check_bank("t4 commit");

    // 5. Section 3 on the 3-section instance: error, no bank write
    wr_valid3 = 1'b1;
    wr_sec3   = 2'd3;
    for (int i = 0; i < 5; i++) begin
      wr_data3 = 16'h7000 + 16'(i);
      tick();
      wr_sec3 = 2'd0;
    end
    wr_valid3 = 1'b0;
    check("t5 err", 64'(err3), 64'd1);
    check("t5 busy", 64'(busy3), 64'd0);
    check("t5 wr_ready", 64'(wr_ready3), 64'd1);
    commit_en3 = 1'b1;
    tick();
    commit_en3 = 1'b0;
    check("t5 err single", 64'(err3), 64'd0);
    check("t5 no updated", 64'(updated3), 64'd0);
    check("t5 b0 bank", 64'(coef3_b0), 64'h0000_4000_4000_4000);
    check("t5 a2 bank", 64'(coef3_a2), 64'd0);
    tick();
    check("t5 no updated later", 64'(updated3), 64'd0);

    // 6a. Reset while pending
    send_frame(2'd3, 16'h0F0F, 16'h0E0E, 16'h0D0D, 16'h0C0C, 16'h0B0B, 1'b0);
    check("t6 pend", 64'(wr_ready), 64'd0);
    rst       = 1'b1;
    commit_en = 1'b1;
    tick();
    rst       = 1'b0;
    commit_en = 1'b0;
    model_reset();
    check_bank("t6 reset");
    check("t6 reset updated", 64'(updated), 64'd0);
    check("t6 reset busy", 64'(busy), 64'd0);
    pulse_commit();
    check("t6 frame lost", 64'(updated), 64'd0);
    check_bank("t6 after commit");

    // 6b. Abort together with commit in PEND
    send_frame(2'd2, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0FED, 1'b0);
    abort     = 1'b1;
    commit_en = 1'b1;
    tick();
    abort     = 1'b0;
    commit_en = 1'b0;
    check("t6 abort+commit updated", 64'(updated), 64'd0);
    check("t6 abort+commit busy", 64'(busy), 64'd0);
    check_bank("t6 abort+commit bank");
    pulse_commit();
    check("t6 abort later commit", 64'(updated), 64'd0);
    check_bank("t6 final bank");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
